// File: rtl/alu_acc_stage.sv
// Accumulator stage behind the 8-bit ALU: registers results, feeds A/Ci back, keeps Z/C/N flags and a result FIFO.
// Optional feature: define ALU_ACC_SAT_EN to saturate the accumulator to all-ones on carry-out.
module alu_acc_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH:0]           alu_o,
    input  logic                     acc_clr,
    input  logic                     acc_load,
    input  logic [WIDTH-1:0]         load_data,
    output logic [WIDTH-1:0]         acc_q,
    output logic                     ci_q,
    output logic                     flag_z,
    output logic                     flag_c,
    output logic                     flag_n,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH:0]           out_data,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    occ_e             occ;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] acc_next;

    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign fifo_cnt = wr_ptr - rd_ptr;

    // Equal index with differing wrap bit means the writer has lapped the reader.
    always_comb begin
        occ = OCC_PARTIAL;
        if (wr_ptr == rd_ptr)
            occ = OCC_EMPTY;
        else if ((wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]))
            occ = OCC_FULL;
    end

    assign in_ready  = (occ != OCC_FULL) && !acc_clr && !acc_load;
    assign push      = in_valid && in_ready;
    assign out_valid = (occ != OCC_EMPTY);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_idx] : '0;

`ifdef ALU_ACC_SAT_EN
    assign acc_next = alu_o[WIDTH] ? '1 : alu_o[WIDTH-1:0];
`else
    assign acc_next = alu_o[WIDTH-1:0];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ci_q   <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
        end else if (acc_clr) begin
            acc_q  <= '0;
            ci_q   <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
        end else if (acc_load) begin
            acc_q <= load_data;
            ci_q  <= 1'b0;
        end else if (push) begin
            acc_q  <= acc_next;
            ci_q   <= alu_o[WIDTH];
            flag_z <= (alu_o[WIDTH-1:0] == '0);
            flag_c <= alu_o[WIDTH];
            flag_n <= alu_o[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; emptiness lives in the pointers and out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_idx] <= alu_o;
    end

endmodule

// File: tb/tb_alu_acc_stage.sv
// Scoreboard bench for alu_acc_stage: directed scenarios followed by randomized traffic against a behavioural model.
module tb_alu_acc_stage;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   alu_o;
    logic         acc_clr;
    logic         acc_load;
    logic [W-1:0] load_data;
    logic [W-1:0] acc_q;
    logic         ci_q;
    logic         flag_z;
    logic         flag_c;
    logic         flag_n;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_data;
    logic [2:0]   fifo_cnt;

    alu_acc_stage #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_o     (alu_o),
        .acc_clr   (acc_clr),
        .acc_load  (acc_load),
        .load_data (load_data),
        .acc_q     (acc_q),
        .ci_q      (ci_q),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fifo_cnt  (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: expected FIFO contents in order, plus architectural registers.
    logic [W:0]   sb [$];
    int           m_cnt;
    int unsigned  m_acc;
    bit           m_ci;
    bit           m_z;
    bit           m_c;
    bit           m_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt = 0;
        m_acc = 0;
        m_ci  = 0;
        m_z   = 0;
        m_c   = 0;
        m_n   = 0;
    endtask

    // Monitor: whenever the DUT presents a head, it must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_head", {55'd0, out_data}, 64'hDEAD);
                end else begin
                    check("fifo_head", {55'd0, out_data}, {55'd0, sb[0]});
                    if (out_ready)
                        void'(sb.pop_front());
                end
            end
        end
    end

    // One clock: inputs applied now (just after a rising edge), state checked at the falling edge.
    task automatic step(input bit iv, input logic [W:0] d, input bit clr, input bit ld,
                        input logic [W-1:0] ldd, input bit ordy);
        bit exp_rdy;
        bit acc_ev;
        bit pop_ev;
        in_valid  = iv;
        alu_o     = d;
        acc_clr   = clr;
        acc_load  = ld;
        load_data = ldd;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (m_cnt < D) && !clr && !ld;
        check("in_ready",  {63'd0, in_ready},  {63'd0, exp_rdy});
        check("acc_q",     {56'd0, acc_q},     64'(m_acc));
        check("ci_q",      {63'd0, ci_q},      {63'd0, m_ci});
        check("flag_z",    {63'd0, flag_z},    {63'd0, m_z});
        check("flag_c",    {63'd0, flag_c},    {63'd0, m_c});
        check("flag_n",    {63'd0, flag_n},    {63'd0, m_n});
        check("out_valid", {63'd0, out_valid}, {63'd0, (m_cnt != 0)});
        check("fifo_cnt",  {61'd0, fifo_cnt},  64'(m_cnt));
        @(posedge clk);
        acc_ev = iv && exp_rdy;
        pop_ev = (m_cnt > 0) && ordy;
        if (clr) begin
            m_acc = 0; m_ci = 0; m_z = 0; m_c = 0; m_n = 0;
        end else if (ld) begin
            m_acc = int'(ldd);
            m_ci  = 0;
        end else if (acc_ev) begin
            m_ci = d[W];
`ifdef ALU_ACC_SAT_EN
            m_acc = d[W] ? (2**W - 1) : int'(d) % (2**W);
`else
            m_acc = int'(d) % (2**W);
`endif
            m_z = (int'(d) % (2**W)) == 0;
            m_c = d[W];
            m_n = ((int'(d) / (2**(W-1))) % 2) == 1;
        end
        if (acc_ev)
            sb.push_back(d);
        m_cnt = m_cnt + int'(acc_ev) - int'(pop_ev);
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, '0, 0, 0, '0, ordy);
    endtask

    initial begin
        in_valid = 0; alu_o = '0; acc_clr = 0; acc_load = 0; load_data = '0; out_ready = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0);

        // Reset with three results queued: everything clears immediately.
        step(1, 9'h011, 0, 0, '0, 0);
        step(1, 9'h122, 0, 0, '0, 0);
        step(1, 9'h033, 0, 0, '0, 0);
        idle(0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_acc_q",     {56'd0, acc_q},     64'd0);
        check("rst_ci_q",      {63'd0, ci_q},      64'd0);
        check("rst_flags",     {61'd0, flag_z, flag_c, flag_n}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_fifo_cnt",  {61'd0, fifo_cnt},  64'd0);
        check("rst_out_data",  {55'd0, out_data},  64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single accept, negative result, held in the FIFO.
        step(1, 9'h0A0, 0, 0, '0, 0);
        idle(0);
        // Carry-out with zero low byte.
        step(1, 9'h100, 0, 0, '0, 0);
        idle(0);
        repeat (3) idle(1);

        // Fill to full; a fifth offer is refused and the accumulator keeps the fourth result.
        step(1, 9'h001, 0, 0, '0, 0);
        step(1, 9'h1F2, 0, 0, '0, 0);
        step(1, 9'h083, 0, 0, '0, 0);
        step(1, 9'h044, 0, 0, '0, 0);
        step(1, 9'h1EE, 0, 0, '0, 0);
        repeat (5) idle(1);

        // Steady push+pop at occupancy two, walking pointers past the wrap.
        step(1, 9'h010, 0, 0, '0, 0);
        step(1, 9'h020, 0, 0, '0, 0);
        for (int i = 0; i < 6; i++)
            step(1, 9'(9'h130 + i), 0, 0, '0, 1);
        repeat (3) idle(1);

        // Clear beats load beats accept; then load alone.
        step(1, 9'h0C7, 0, 0, '0, 0);
        step(1, 9'h0AA, 1, 1, 8'h55, 0);
        step(1, 9'h081, 0, 0, '0, 0);
        step(1, 9'h0AA, 0, 1, 8'h55, 0);
        repeat (3) idle(1);

        // Randomized traffic with phases of slow and fast draining.
        for (int i = 0; i < 400; i++) begin
            bit rdy_bias;
            rdy_bias = ((i / 50) % 2) == 0;
            step($urandom_range(0, 3) != 0,
                 9'($urandom),
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 16) == 0,
                 8'($urandom),
                 rdy_bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end
        repeat (8) idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
